// File: rtl/ssd_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scan driver with per-frame shadowing, dead-time and blink.
// Optional macro SSD_DIM_EN adds a bright[1:0] input that shortens the per-slot on-time.
module ssd_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEADTIME    = 16,
  parameter int BLINK_DIV   = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] disp0,
  input  logic [7:0] disp1,
  input  logic [7:0] disp2,
  input  logic [7:0] disp3,
  input  logic [3:0] blink_mask,
`ifdef SSD_DIM_EN
  input  logic [1:0] bright,
`endif
  output logic [7:0] seven,
  output logic [3:0] segment,
  output logic       frame_tick
);

  // one extra bit so the window end can equal REFRESH_DIV itself
  localparam int SLOT_W  = $clog2(REFRESH_DIV + 1);
  localparam int FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]  SLOT_DEAD  = SLOT_W'(DEADTIME);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_DIV - 1);

  logic [SLOT_W-1:0]  slot_cnt_r;
  logic [1:0]         digit_idx_r;
  logic [FRAME_W-1:0] frame_cnt_r;
  logic               blink_phase_r;
  logic [3:0][7:0]    disp_sh_r;
  logic [3:0]         mask_sh_r;
  logic [7:0]         seven_r;
  logic [3:0]         segment_r;
  logic               frame_tick_r;

  logic               slot_wrap_s;
  logic               frame_bnd_s;
  logic [SLOT_W-1:0]  win_end_s;
  logic               active_s;
  logic [7:0]         seven_next_s;
  logic [3:0]         segment_next_s;

`ifdef SSD_DIM_EN
  logic [1:0]  bright_sh_r;
  logic [31:0] on_len_s;

  // Dimmed on-time: a quarter-step fraction of the post-dead-time window.
  always_comb begin
    on_len_s  = (32'(REFRESH_DIV - DEADTIME) * (32'(bright_sh_r) + 32'd1)) >> 2;
    win_end_s = SLOT_W'(32'(DEADTIME) + on_len_s);
  end
`else
  // Full on-time: active until the end of the slot.
  always_comb begin
    win_end_s = SLOT_W'(REFRESH_DIV);
  end
`endif

  // Slot/frame boundary detection and the active-window test.
  always_comb begin
    slot_wrap_s = (slot_cnt_r == SLOT_LAST);
    frame_bnd_s = slot_wrap_s && (digit_idx_r == 2'd3);
    active_s    = (slot_cnt_r >= SLOT_DEAD) && (slot_cnt_r < win_end_s);
  end

  // Next-output decode: blank unless in the active window and not blink-suppressed.
  always_comb begin
    seven_next_s   = 8'hFF;
    segment_next_s = 4'b1111;
    if (active_s && !(blink_phase_r && mask_sh_r[digit_idx_r])) begin
      seven_next_s = disp_sh_r[digit_idx_r];
      case (digit_idx_r)
        2'd0:    segment_next_s = 4'b1110;
        2'd1:    segment_next_s = 4'b1101;
        2'd2:    segment_next_s = 4'b1011;
        2'd3:    segment_next_s = 4'b0111;
        default: segment_next_s = 4'b1111;
      endcase
    end else begin
      seven_next_s   = 8'hFF;
      segment_next_s = 4'b1111;
    end
  end

  // Scan counters: slot within digit, digit within frame, frame within blink half-period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt_r    <= {SLOT_W{1'b0}};
      digit_idx_r   <= 2'd0;
      frame_cnt_r   <= {FRAME_W{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (slot_wrap_s) begin
      slot_cnt_r  <= {SLOT_W{1'b0}};
      digit_idx_r <= digit_idx_r + 2'd1;
      if (digit_idx_r == 2'd3) begin
        if (frame_cnt_r == FRAME_LAST) begin
          frame_cnt_r   <= {FRAME_W{1'b0}};
          blink_phase_r <= ~blink_phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
        end
      end
    end else begin
      slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
    end
  end

  // Shadow registers: inputs only take effect at the frame boundary, so a frame never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_sh_r <= {4{8'hFF}};
      mask_sh_r <= 4'b0000;
`ifdef SSD_DIM_EN
      bright_sh_r <= 2'b00;
`endif
    end else if (frame_bnd_s) begin
      disp_sh_r <= {disp3, disp2, disp1, disp0};
      mask_sh_r <= blink_mask;
`ifdef SSD_DIM_EN
      bright_sh_r <= bright;
`endif
    end
  end

  // Output registers: decode lands one cycle after the counter state it reflects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seven_r      <= 8'hFF;
      segment_r    <= 4'b1111;
      frame_tick_r <= 1'b0;
    end else begin
      seven_r      <= seven_next_s;
      segment_r    <= segment_next_s;
      frame_tick_r <= frame_bnd_s;
    end
  end

  assign seven      = seven_r;
  assign segment    = segment_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver at REFRESH_DIV=8, DEADTIME=2, BLINK_DIV=2.
module tb_ssd_scan_driver;

  localparam int RD    = 8;
  localparam int DT    = 2;
  localparam int BD    = 2;
  localparam int FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] disp0, disp1, disp2, disp3;
  logic [3:0] blink_mask;
  logic [1:0] bright;
  logic [7:0] seven;
  logic [3:0] segment;
  logic       frame_tick;

  ssd_scan_driver #(.REFRESH_DIV(RD), .DEADTIME(DT), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .disp0      (disp0),
    .disp1      (disp1),
    .disp2      (disp2),
    .disp3      (disp3),
    .blink_mask (blink_mask),
`ifdef SSD_DIM_EN
    .bright     (bright),
`endif
    .seven      (seven),
    .segment    (segment),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n = 0;
  logic [7:0]  m_disp [4];
  logic [3:0]  m_mask;
  logic [1:0]  m_bright;
  logic [12:0] q [$];

  task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at edge %0d: got tick/seven/segment=%h, expected %h", nm, n, act, exp);
  endtask

  // Expected {frame_tick, seven, segment} just after the n-th edge since reset release.
  function automatic logic [12:0] model(input int k);
    int s, dig, slot, f, wend;
    logic ph, tk;
    logic [7:0] sv;
    logic [3:0] sg;
    s    = (k - 1) % FRAME;
    dig  = s / RD;
    slot = s % RD;
    f    = (k - 1) / FRAME;
    ph   = ((f / BD) % 2) == 1;
    tk   = (k % FRAME) == 0;
`ifdef SSD_DIM_EN
    wend = DT + ((RD - DT) * (int'(m_bright) + 1)) / 4;
`else
    wend = RD;
`endif
    sv = 8'hFF;
    sg = 4'b1111;
    if (slot >= DT && slot < wend && !(ph && m_mask[dig])) begin
      sv = m_disp[dig];
      sg = 4'b1111;
      sg[dig] = 1'b0;
    end
    return {tk, sv, sg};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    n++;
    q.push_back(model(n));
    if (n % FRAME == 0) begin
      m_disp[0] = disp0; m_disp[1] = disp1; m_disp[2] = disp2; m_disp[3] = disp3;
      m_mask    = blink_mask;
      m_bright  = bright;
    end
  endtask

  task automatic run(input int k);
    repeat (k) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset", {frame_tick, seven, segment}, {1'b0, 8'hFF, 4'b1111});
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_hold", {frame_tick, seven, segment}, {1'b0, 8'hFF, 4'b1111});
    for (int i = 0; i < 4; i++) m_disp[i] = 8'hFF;
    m_mask   = 4'b0000;
    m_bright = 2'b00;
    n        = 0;
    rst      = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents an output, compare it with the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) check("scan", {frame_tick, seven, segment}, q.pop_front());
  end

  initial begin
    disp0 = 8'hC0; disp1 = 8'hF9; disp2 = 8'hA4; disp3 = 8'hB0;
    blink_mask = 4'b0000;
    bright     = 2'b01;
    do_reset();
    run(35);               // first frame blank, second frame starts showing digits
    disp1 = 8'h92;         // mid-frame change while digit 0 is scanning
    run(61);
    run(4);
    blink_mask = 4'b0100;  // loads at edge 128; blanked frames 6 and 7
    run(190);
    blink_mask = 4'b0000;  // loads at edge 320
    run(50);               // digit 2 active window of frame 10
    bright = 2'b11;
    do_reset();
    run(70);
    repeat (3) @(negedge clk);
    #1;
    check("queue_drain", 13'(q.size()), 13'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
